forwarding_scoreboard_unit: RTL and testbench

// Parametrised EX-stage operand forwarding plus register scoreboard for the RV32 pipeline.

---
 rtl/forwarding_scoreboard_unit.sv | 107 ++++++++++
 tb/tb_forwarding_scoreboard_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard_unit.sv
// EX-stage operand forwarding select, load-use stall detection and a per-register
// countdown scoreboard that holds dependents of long-latency ops until results land.
module forwarding_scoreboard_unit #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned MAX_LAT        = 34,
    parameter int unsigned LAT_W          = 6,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]        rs_ex,
    input  logic [NUM_SRC-1:0]               rs_used,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] rd_stg,
    input  logic [NUM_FWD_STAGES-1:0]        wr_stg,
    input  logic [NUM_FWD_STAGES-1:0]        rdy_stg,
    input  logic                             issue_valid,
    input  logic [REG_AW-1:0]                issue_rd,
    input  logic [LAT_W-1:0]                 issue_lat,
    input  logic                             flush,
    output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
    output logic                             stall_ex,
    output logic                             issue_ready,
    output logic [NUM_REGS-1:0]              pending,
    output logic [STALL_CNT_W-1:0]           stall_cycles
);

    logic [LAT_W-1:0]  cnt [NUM_REGS];
    logic [REG_AW-1:0] rs_cur;
    logic [REG_AW-1:0] rd_cur;
    logic [SEL_W-1:0]  sel_cur;
    logic              rdy_cur;
    logic              accept;
    logic              lat_ok;

    // Busy bit per register; register 0 can never be pending
    always_comb begin
        pending = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            pending[r] = (cnt[r] != '0);
        end
    end

    // Youngest matching producer wins; its readiness decides the load-use stall
    always_comb begin
        fwd_sel  = '0;
        stall_ex = 1'b0;
        rs_cur   = '0;
        rd_cur   = '0;
        sel_cur  = '0;
        rdy_cur  = 1'b1;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            rs_cur  = rs_ex[i*REG_AW +: REG_AW];
            sel_cur = '0;
            rdy_cur = 1'b1;
            for (int k = int'(NUM_FWD_STAGES) - 1; k >= 0; k--) begin
                rd_cur = rd_stg[k*REG_AW +: REG_AW];
                if (wr_stg[k] && (rd_cur != '0) && (rd_cur == rs_cur)) begin
                    sel_cur = SEL_W'(k + 1);
                    rdy_cur = rdy_stg[k];
                end
            end
            fwd_sel[i*SEL_W +: SEL_W] = sel_cur;
            if (rs_used[i] && (sel_cur != '0) && !rdy_cur) begin
                stall_ex = 1'b1;
            end
            if (rs_used[i] && (rs_cur != '0) && pending[rs_cur]) begin
                stall_ex = 1'b1;
            end
        end
    end

    assign issue_ready = (issue_rd == '0) || !pending[issue_rd];
    assign lat_ok      = (issue_lat != '0) && (issue_lat <= LAT_W'(MAX_LAT));
    assign accept      = issue_valid && issue_ready && !flush && !stall_ex &&
                         (issue_rd != '0) && lat_ok;

    // Load on accept, otherwise count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                if (accept && (issue_rd == REG_AW'(r))) begin
                    cnt[r] <= issue_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // Saturating stall performance counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_ex && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard_unit.sv
// Randomized and directed checks of forwarding_scoreboard_unit against a
// time-stamp based reference model (register busy until an absolute cycle).
module tb_forwarding_scoreboard_unit;

    localparam int unsigned NUM_SRC  = 2;
    localparam int unsigned NUM_FWD  = 2;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned MAX_LAT  = 34;
    localparam int unsigned SAT      = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_ex;
    logic [1:0]  rs_used;
    logic [9:0]  rd_stg;
    logic [1:0]  wr_stg;
    logic [1:0]  rdy_stg;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [5:0]  issue_lat;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall_ex;
    logic        issue_ready;
    logic [31:0] pending;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int busy_until [NUM_REGS];
    int stall_cnt = 0;

    forwarding_scoreboard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_ex        (rs_ex),
        .rs_used      (rs_used),
        .rd_stg       (rd_stg),
        .wr_stg       (wr_stg),
        .rdy_stg      (rdy_stg),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall_ex     (stall_ex),
        .issue_ready  (issue_ready),
        .pending      (pending),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_busy(input int r);
        return (r != 0) && (cyc < busy_until[r]);
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) p[r] = model_busy(r);
        return p;
    endfunction

    function automatic void model_reset();
        foreach (busy_until[r]) busy_until[r] = 0;
        stall_cnt = 0;
    endfunction

    // Expected combinational outputs from the current inputs and model state
    function automatic void model_comb(output logic [3:0] sel, output logic stall,
                                       output logic ready);
        int rs, rd, s;
        sel   = '0;
        stall = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            rs = int'(rs_ex[i*5 +: 5]);
            s  = 0;
            for (int k = 0; k < int'(NUM_FWD); k++) begin
                rd = int'(rd_stg[k*5 +: 5]);
                if (s == 0 && wr_stg[k] && rd != 0 && rd == rs) s = k + 1;
            end
            sel[i*2 +: 2] = 2'(s);
            if (rs_used[i] && s != 0 && !rdy_stg[s-1]) stall = 1'b1;
            if (rs_used[i] && model_busy(rs)) stall = 1'b1;
        end
        ready = (issue_rd == 0) || !model_busy(int'(issue_rd));
    endfunction

    // Check all outputs, advance the model across the coming edge, then take the edge
    task automatic cycle();
        logic [3:0] es;
        logic       est, erd;
        #2;
        model_comb(es, est, erd);
        check("fwd_sel", 64'(fwd_sel), 64'(es));
        check("stall_ex", 64'(stall_ex), 64'(est));
        check("issue_ready", 64'(issue_ready), 64'(erd));
        check("pending", 64'(pending), 64'(model_pending()));
        check("stall_cycles", 64'(stall_cycles), 64'(stall_cnt));
        if (issue_valid && erd && !flush && !est && issue_rd != 0 &&
            issue_lat >= 1 && int'(issue_lat) <= int'(MAX_LAT))
            busy_until[issue_rd] = cyc + 1 + int'(issue_lat);
        if (est && stall_cnt < int'(SAT)) stall_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_ex = '0; rs_used = '0; rd_stg = '0; wr_stg = '0; rdy_stg = '1;
        issue_valid = 1'b0; issue_rd = '0; issue_lat = '0; flush = 1'b0;
    endtask

    task automatic random_inputs();
        rs_ex       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        rs_used     = 2'($urandom);
        rd_stg      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        wr_stg      = 2'($urandom);
        rdy_stg     = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
        issue_valid = 1'($urandom);
        issue_rd    = 5'($urandom_range(0, 7));
        issue_lat   = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(33, 63))
                                                   : 6'($urandom_range(0, 6));
        flush       = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pending", 64'(pending), 64'(0));
        check("reset_stall_cycles", 64'(stall_cycles), 64'(0));
        check("reset_issue_ready", 64'(issue_ready), 64'(1));
        rst_n = 1'b1;

        // T1: both sources hit both stages, youngest wins
        rs_ex = {5'd5, 5'd5}; rs_used = 2'b11;
        rd_stg = {5'd5, 5'd5}; wr_stg = 2'b11; rdy_stg = 2'b11;
        #1 check("t1_fwd_sel", 64'(fwd_sel), 64'h5);
        check("t1_stall", 64'(stall_ex), 64'(0));
        cycle();

        // T2: younger not-ready load is not masked by an older ready stage
        rs_ex = {5'd0, 5'd7}; rs_used = 2'b01;
        rd_stg = {5'd7, 5'd7}; wr_stg = 2'b11; rdy_stg = 2'b10;
        #1 check("t2_stall", 64'(stall_ex), 64'(1));
        cycle();
        rdy_stg = 2'b11;
        #1 check("t2_fwd_sel0", 64'(fwd_sel[1:0]), 64'(1));
        check("t2_stall_clear", 64'(stall_ex), 64'(0));
        cycle();

        // T3: x0 never forwards; non-writing stage never forwards
        rs_ex = {5'd3, 5'd0}; rs_used = 2'b11;
        rd_stg = {5'd0, 5'd0}; wr_stg = 2'b01; rdy_stg = 2'b00;
        cycle();
        rd_stg = {5'd3, 5'd3}; wr_stg = 2'b00;
        #1 check("t3_fwd_sel", 64'(fwd_sel), 64'(0));
        cycle();

        // T4: long-latency op on x9 holds a consumer for exactly 3 cycles
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 6'd3;
        cycle();
        idle_inputs();
        rs_ex = {5'd0, 5'd9}; rs_used = 2'b01; issue_rd = 5'd9;
        for (int c = 0; c < 3; c++) begin
            #1 check("t4_stall", 64'(stall_ex), 64'(1));
            check("t4_issue_ready", 64'(issue_ready), 64'(0));
            cycle();
        end
        #1 check("t4_stall_done", 64'(stall_ex), 64'(0));
        cycle();

        // T5: flush, stall and rd=0 all suppress the entry
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd11; issue_lat = 6'd4; flush = 1'b1;
        cycle();
        flush = 1'b0; rs_ex = {5'd0, 5'd2}; rs_used = 2'b01;
        rd_stg = {5'd0, 5'd2}; wr_stg = 2'b01; rdy_stg = 2'b10;
        cycle();
        idle_inputs();
        issue_valid = 1'b1; issue_lat = 6'd5;
        cycle();
        #1 check("t5_pending", 64'(pending), 64'(0));
        issue_rd = 5'd12; issue_lat = 6'd40;
        cycle();
        issue_lat = 6'd0;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            random_inputs();
            cycle();
        end

        // T6: async reset mid-flight, then stall counter saturation
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 6'd3;
        for (int n = 0; n < 40; n++) begin
            if (model_busy(9)) issue_valid = 1'b0;
            cycle();
            if (!issue_valid) break;
        end
        idle_inputs();
        cycle();
        check("t6_pre_pending", 64'(pending[9]), 64'(1));
        rst_n = 1'b0;
        #1 check("t6_async_pending", 64'(pending), 64'(0));
        check("t6_async_stall_cycles", 64'(stall_cycles), 64'(0));
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rs_ex = {5'd0, 5'd7}; rs_used = 2'b01;
        rd_stg = {5'd0, 5'd7}; wr_stg = 2'b01; rdy_stg = 2'b00;
        repeat (int'(SAT) + 5) cycle();
        #1 check("t6_saturated", 64'(stall_cycles), 64'(SAT));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
